// File: rtl/mp_add_seq_pkg.sv
// ============================================================================
// Module : mp_add_seq_pkg
// Brief  : Shared word width, FSM state encoding and index-width helper for
//          the multi-precision adder sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mp_add_seq_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word counter width; a single-word operand still needs a 1-bit counter.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mp_add_seq_fulladd16.sv
// ============================================================================
// Module : fulladd16
// Brief  : Combinational 16-bit ripple-carry adder, one full-adder cell per bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fulladd16
  import mp_add_seq_pkg::*;
(
  output logic [WORD_W-1:0] sum,
  output logic              c_out,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              c_in
);

  logic [WORD_W:0] chain;

  assign chain[0] = c_in;

  for (genvar i = 0; i < WORD_W; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ chain[i];
    assign chain[i + 1] = (a[i] & b[i]) | (chain[i] & (a[i] ^ b[i]));
  end

  assign c_out = chain[WORD_W];

endmodule

`default_nettype wire

// File: rtl/mp_add_seq.sv
// ============================================================================
// Module : mp_add_seq
// Brief  : Multi-precision adder sequencer, one 16-bit word per clock, LSW
//          first, carry registered between words. Optional subtract mode is
//          enabled by defining MP_ADD_SEQ_SUB_EN (adds the in_sub port).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] in_a,
  input  logic [WORD_W*WORDS-1:0] in_b,
  input  logic                    in_cin,
`ifdef MP_ADD_SEQ_SUB_EN
  input  logic                    in_sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] out_sum,
  output logic                    out_cout,
  output logic                    out_ovf,
  output logic                    busy
);

  localparam int                IDX_W    = idx_width(WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  state_t                         state;
  state_t                         state_nxt;
  logic [IDX_W-1:0]               idx;
  logic                           carry;
  logic [WORDS-1:0][WORD_W-1:0]   op_a;
  logic [WORDS-1:0][WORD_W-1:0]   op_b;
  logic [WORDS-1:0][WORD_W-1:0]   sum_words;
  logic                           cout_flag;
  logic                           ovf_flag;

  logic                           accept;
  logic                           last_word;
  logic [WORD_W-1:0]              word_a;
  logic [WORD_W-1:0]              word_b;
  logic [WORD_W-1:0]              word_sum;
  logic                           word_cout;
  logic                           load_carry;

`ifdef MP_ADD_SEQ_SUB_EN
  logic                           sub_mode;

  // Subtraction is A + ~B + 1; in_cin then acts as a borrow, hence the inversion.
  assign word_b     = op_b[idx] ^ {WORD_W{sub_mode}};
  assign load_carry = in_cin ^ in_sub;
`else
  assign word_b     = op_b[idx];
  assign load_carry = in_cin;
`endif

  assign word_a    = op_a[idx];
  assign accept    = in_valid & in_ready;
  assign last_word = (idx == LAST_IDX);

  fulladd16 u_adder (
    .sum   (word_sum),
    .c_out (word_cout),
    .a     (word_a),
    .b     (word_b),
    .c_in  (carry)
  );

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_word) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand latches, word counter, carry register and result
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      sum_words <= '0;
      cout_flag <= 1'b0;
      ovf_flag  <= 1'b0;
    end else if (accept) begin
      op_a  <= in_a;
      op_b  <= in_b;
      carry <= load_carry;
      idx   <= '0;
    end else if (state == RUN) begin
      sum_words[idx] <= word_sum;
      carry          <= word_cout;
      idx            <= last_word ? '0 : idx + 1'b1;
      if (last_word) begin
        cout_flag <= word_cout;
        ovf_flag  <= (word_a[WORD_W-1] == word_b[WORD_W-1]) &&
                     (word_sum[WORD_W-1] != word_a[WORD_W-1]);
      end
    end
  end

`ifdef MP_ADD_SEQ_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_mode <= 1'b0;
    end else if (accept) begin
      sub_mode <= in_sub;
    end
  end
`endif

  assign out_sum  = sum_words;
  assign out_cout = cout_flag;
  assign out_ovf  = ovf_flag;

endmodule

`default_nettype wire

// File: tb/tb_mp_add_seq.sv
// ============================================================================
// Module : tb_mp_add_seq
// Brief  : Directed self-checking bench for mp_add_seq with WORDS=4.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mp_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef MP_ADD_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands at a falling edge; they are accepted on the next rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
`ifdef MP_ADD_SEQ_SUB_EN
    in_sub   = sub;
`else
    if (sub) $display("note: subtract request ignored in add-only build");
`endif
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_result(input string tag);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, lat, 4);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] s,
                              input logic c, input logic v);
    chk({tag, "_sum"},  out_sum,  s);
    chk({tag, "_cout"}, out_cout, c);
    chk({tag, "_ovf"},  out_ovf,  v);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_dropped"}, out_valid, 1'b0);
    chk({tag, "_ready_back"},    in_ready,  1'b1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum",   out_sum,   64'h0);
    chk("rst_out_cout",  out_cout,  1'b0);
    chk("rst_out_ovf",   out_ovf,   1'b0);
    chk("rst_busy",      busy,      1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: carry across the first word boundary
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    chk("t1_in_ready_run", in_ready, 1'b0);
    wait_result("t1");
    check_result("t1", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    handoff("t1");

    // 2: carry-in ripples through every word
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    wait_result("t2");
    check_result("t2", 64'h0, 1'b1, 1'b0);
    handoff("t2");

    // 3: positive + positive -> signed overflow
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_result("t3");
    check_result("t3", 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    handoff("t3");

    // 4: back-pressure with a pending operand that must not be taken early
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
    in_a     = 64'h8000_0000_0000_0000;
    in_b     = 64'h8000_0000_0000_0000;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    wait_result("t4a");
    check_result("t4a", 64'h2345_6789_ABCD_F002, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t4_hold_sum",   out_sum,   64'h2345_6789_ABCD_F002);
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_ready", in_ready,  1'b0);
    end
    chk("t4_hold_cout", out_cout, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4_release_valid", out_valid, 1'b0);
    chk("t4_release_ready", in_ready,  1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4b_accepted", in_ready, 1'b0);
    wait_result("t4b");
    check_result("t4b", 64'h0, 1'b1, 1'b1);
    handoff("t4b");

    // 5: asynchronous reset in the middle of RUN (idx=2)
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t5_mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_in_ready",  in_ready,  1'b1);
    chk("t5_rst_out_valid", out_valid, 1'b0);
    chk("t5_rst_out_sum",   out_sum,   64'h0);
    chk("t5_rst_out_cout",  out_cout,  1'b0);
    chk("t5_rst_out_ovf",   out_ovf,   1'b0);
    chk("t5_rst_busy",      busy,      1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    wait_result("t5");
    check_result("t5", 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    handoff("t5");

`ifdef MP_ADD_SEQ_SUB_EN
    // 6: subtraction with borrow and without
    start_op(64'h5, 64'h7, 1'b0, 1'b1);
    wait_result("t6a");
    check_result("t6a", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    handoff("t6a");
    start_op(64'h7, 64'h5, 1'b0, 1'b1);
    wait_result("t6b");
    check_result("t6b", 64'h2, 1'b1, 1'b0);
    handoff("t6b");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
